// File: rtl/tile_spawner.sv
// Places new 2/4 tiles on the 4x4 board: snapshots the empty-cell mask, takes a
// random start cell per tile and scans circularly to the first empty cell.
module tile_spawner #(
  parameter int unsigned FOUR_THRESH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spawn_req,
  input  logic        init_req,
  input  logic [15:0] empty_mask,
  input  logic [7:0]  rand_num,
  output logic        busy,
  output logic        spawn_valid,
  output logic [3:0]  spawn_idx,
  output logic [1:0]  spawn_val,
  output logic        done,
  output logic        board_full,
  output logic [2:0]  dbg_state
);

  // Handshake: a request is taken only on an edge where the block is IDLE
  // (busy=0); spawn_valid/done/board_full are single-cycle strobes with no
  // back-pressure, and a request seen while busy=1 is dropped.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_SCAN   = 3'd2,
    S_EMIT   = 3'd3,
    S_DONE   = 3'd4,
    S_FAIL   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [1:0]  remaining_q, remaining_d;
  logic        four_q, four_d;
  logic        busy_q, busy_d;
  logic        spawn_valid_q, spawn_valid_d;
  logic [3:0]  spawn_idx_q, spawn_idx_d;
  logic [1:0]  spawn_val_q, spawn_val_d;
  logic        done_q, done_d;
  logic        board_full_q, board_full_d;

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    ptr_d         = ptr_q;
    remaining_d   = remaining_q;
    four_d        = four_q;
    busy_d        = busy_q;
    spawn_valid_d = 1'b0;
    spawn_idx_d   = spawn_idx_q;
    spawn_val_d   = spawn_val_q;
    done_d        = 1'b0;
    board_full_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (init_req || spawn_req) begin
          remaining_d = init_req ? 2'd2 : 2'd1;
          mask_d      = empty_mask;
          busy_d      = 1'b1;
          state_d     = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (mask_q == 16'h0000) begin
          done_d       = 1'b1;
          board_full_d = 1'b1;
          state_d      = S_FAIL;
        end else begin
          ptr_d   = rand_num[3:0];
          four_d  = ({1'b0, rand_num[7:4]} < 5'(FOUR_THRESH));
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // Strobe outputs are loaded on the edge entering EMIT so they are registered.
        if (mask_q[ptr_q]) begin
          spawn_valid_d = 1'b1;
          spawn_idx_d   = ptr_q;
          spawn_val_d   = four_q ? 2'd2 : 2'd1;
          state_d       = S_EMIT;
        end else begin
          ptr_d = ptr_q + 4'd1;
        end
      end
      S_EMIT: begin
        mask_d[ptr_q] = 1'b0;
        remaining_d   = remaining_q - 2'd1;
        if (remaining_q == 2'd1) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_SAMPLE;
        end
      end
      S_DONE, S_FAIL: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mask_q        <= 16'h0000;
      ptr_q         <= 4'd0;
      remaining_q   <= 2'd0;
      four_q        <= 1'b0;
      busy_q        <= 1'b0;
      spawn_valid_q <= 1'b0;
      spawn_idx_q   <= 4'd0;
      spawn_val_q   <= 2'd0;
      done_q        <= 1'b0;
      board_full_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      ptr_q         <= ptr_d;
      remaining_q   <= remaining_d;
      four_q        <= four_d;
      busy_q        <= busy_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_idx_q   <= spawn_idx_d;
      spawn_val_q   <= spawn_val_d;
      done_q        <= done_d;
      board_full_q  <= board_full_d;
    end
  end

  assign busy        = busy_q;
  assign spawn_valid = spawn_valid_q;
  assign spawn_idx   = spawn_idx_q;
  assign spawn_val   = spawn_val_q;
  assign done        = done_q;
  assign board_full  = board_full_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_tile_spawner.sv
// Randomized scoreboard bench for tile_spawner: a placement model predicts each
// spawn/done/board_full event with its cycle; a monitor pops and compares.
module tb_tile_spawner;
  localparam int unsigned FOUR_THRESH = 2;
  localparam int W = 24;  // {kind[1:0], idx[3:0], val[1:0], cycle[15:0]}

  logic        clk, rst;
  logic        spawn_req, init_req;
  logic [15:0] empty_mask;
  logic [7:0]  rand_num;
  logic        busy, spawn_valid, done, board_full;
  logic [3:0]  spawn_idx;
  logic [1:0]  spawn_val;
  logic [2:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  logic [15:0]  cyc;
  int cmps, errs;

  tile_spawner #(.FOUR_THRESH(FOUR_THRESH)) dut (
    .clk(clk), .rst(rst), .spawn_req(spawn_req), .init_req(init_req),
    .empty_mask(empty_mask), .rand_num(rand_num), .busy(busy),
    .spawn_valid(spawn_valid), .spawn_idx(spawn_idx), .spawn_val(spawn_val),
    .done(done), .board_full(board_full), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 16'd0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    cmps++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // monitor: kind 0 = spawn, 1 = done, 2 = done+board_full, 3 = illegal combination
  always @(negedge clk) begin
    if (!rst && (spawn_valid || done || board_full)) begin
      logic [1:0]   kind;
      logic [W-1:0] obs, e;
      if (spawn_valid) kind = (done || board_full) ? 2'd3 : 2'd0;
      else if (board_full) kind = done ? 2'd2 : 2'd3;
      else kind = 2'd1;
      obs = {kind, (kind == 2'd0) ? spawn_idx : 4'd0, (kind == 2'd0) ? spawn_val : 2'd0, cyc};
      cmps++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_event: got kind=%0d idx=%0d val=%0d cyc=%0d, no event expected",
                 obs[23:22], obs[21:18], obs[17:16], obs[15:0]);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errs++;
          $display("FAIL event: got kind=%0d idx=%0d val=%0d cyc=%0d, expected kind=%0d idx=%0d val=%0d cyc=%0d",
                   obs[23:22], obs[21:18], obs[17:16], obs[15:0],
                   e[23:22], e[21:18], e[17:16], e[15:0]);
        end
      end
    end
  end

  // Placement model: each tile scans from its random start to the first empty
  // cell; times are edge offsets from the accepting edge.
  task automatic model(input bit init, input logic [15:0] mask, input logic [7:0] rnd,
                       input logic [15:0] base);
    logic [15:0] m;
    int remaining, se, k, p;
    m = mask;
    remaining = init ? 2 : 1;
    se = 1;
    while (remaining > 0) begin
      if (m == 16'h0000) begin
        exp_q.push_back({2'd2, 4'd0, 2'd0, 16'(se) + base});
        remaining = 0;
      end else begin
        p = int'(rnd[3:0]);
        k = 0;
        while (!m[p]) begin
          p = (p + 1) % 16;
          k++;
        end
        exp_q.push_back({2'd0, 4'(p), (int'(rnd[7:4]) < FOUR_THRESH) ? 2'd2 : 2'd1,
                         16'(se + 1 + k) + base});
        m[p] = 1'b0;
        remaining--;
        if (remaining == 0) exp_q.push_back({2'd1, 4'd0, 2'd0, 16'(se + 2 + k) + base});
        else se = se + 3 + k;
      end
    end
  endtask

  // driver: issue one request, then pepper the busy window with ignored requests
  // and mask changes while rand_num stays fixed
  task automatic run_req(input bit init, input bit spawn, input logic [15:0] mask,
                         input logic [7:0] rnd);
    int budget;
    @(negedge clk);
    init_req   = init;
    spawn_req  = spawn;
    empty_mask = mask;
    rand_num   = rnd;
    @(posedge clk);
    #1;
    model(init, mask, rnd, cyc);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    init_req  = 1'b0;
    spawn_req = 1'b0;
    budget = 80;
    while (budget > 0) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
      budget--;
      if ($urandom_range(0, 3) == 0) begin
        spawn_req  = 1'($urandom_range(0, 1));
        init_req   = 1'($urandom_range(0, 1));
        empty_mask = 16'($urandom);
      end else begin
        spawn_req = 1'b0;
        init_req  = 1'b0;
      end
    end
    spawn_req = 1'b0;
    init_req  = 1'b0;
    cmps++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL timeout: %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {24'd0, busy, spawn_valid, spawn_idx, spawn_val, done, board_full}, 32'd0);
  endtask

  initial begin
    logic [15:0] m;
    int sel;
    cmps = 0;
    errs = 0;
    rst = 1'b1;
    spawn_req = 1'b0;
    init_req = 1'b0;
    empty_mask = 16'h0000;
    rand_num = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle_outputs");

    run_req(1'b0, 1'b1, 16'hFFFF, 8'h35);
    run_req(1'b0, 1'b1, 16'h0001, 8'h0E);
    run_req(1'b1, 1'b1, 16'h0030, 8'h84);
    run_req(1'b0, 1'b1, 16'h0000, 8'h5A);
    run_req(1'b1, 1'b0, 16'h8000, 8'h27);
    run_req(1'b1, 1'b0, 16'h0000, 8'hF3);

    // reset while scanning from cell 1 toward the only empty cell 0
    @(negedge clk);
    spawn_req  = 1'b1;
    empty_mask = 16'h0001;
    rand_num   = 8'h01;
    @(posedge clk);
    #1;
    spawn_req = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("reset_mid_scan");
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check_idle_outputs("after_abort");
    run_req(1'b0, 1'b1, 16'h0001, 8'h01);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: m = 16'hFFFF;
        1: m = 16'h0000;
        2: m = 16'h0001 << $urandom_range(0, 15);
        3: m = 16'($urandom);
        4: m = 16'($urandom) & 16'($urandom);
        default: m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 2) == 0) run_req(1'b1, 1'($urandom_range(0, 1)), m, 8'($urandom));
      else run_req(1'b0, 1'b1, m, 8'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
